mcdf_arbiter: RTL and testbench

Packet-level arbiter of the MCDF datapath, directly upstream of the formatter. It picks one of three slave FIFO channels by programmable priority. It then presents that channel's ID and packet-length select to the formatter and waits for the formatter's acknowledge. Finally it streams exactly one packet of 4/8/16/32 words out of the winning FIFO, marking the last word with `a2f_end_o`.

---
 rtl/mcdf_arbiter_if.sv | 33 +++
 rtl/mcdf_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mcdf_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mcdf_arbiter_if.sv
// Formatter-side handshake of the MCDF arbiter: ID request/acknowledge
// plus the outgoing packet word stream.
interface mcdf_arbiter_if #(parameter int DW = 32);
    logic          fmt_id_req_i;
    logic          f2a_ack_i;
    logic          a2f_val_o;
    logic [1:0]    a2f_id_o;
    logic [DW-1:0] a2f_data_o;
    logic [2:0]    a2f_pkglen_sel_o;
    logic          a2f_end_o;

    // Arbiter side: receives the formatter handshake, drives the word stream.
    modport master (
        input  fmt_id_req_i,
        input  f2a_ack_i,
        output a2f_val_o,
        output a2f_id_o,
        output a2f_data_o,
        output a2f_pkglen_sel_o,
        output a2f_end_o
    );

    // Formatter side.
    modport slave (
        output fmt_id_req_i,
        output f2a_ack_i,
        input  a2f_val_o,
        input  a2f_id_o,
        input  a2f_data_o,
        input  a2f_pkglen_sel_o,
        input  a2f_end_o
    );
endinterface

// File: rtl/mcdf_arbiter.sv
// MCDF packet arbiter: picks one of three FIFO channels by priority, hands
// the channel ID to the formatter, then streams one whole packet out of it.
module mcdf_arbiter #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [2:0]    slv_en_i,
    input  logic [1:0]    slv0_prio_i,
    input  logic [1:0]    slv1_prio_i,
    input  logic [1:0]    slv2_prio_i,
    input  logic [2:0]    slv0_pkglen_i,
    input  logic [2:0]    slv1_pkglen_i,
    input  logic [2:0]    slv2_pkglen_i,
    input  logic          slv0_req_i,
    input  logic          slv1_req_i,
    input  logic          slv2_req_i,
    input  logic [DW-1:0] slv0_data_i,
    input  logic [DW-1:0] slv1_data_i,
    input  logic [DW-1:0] slv2_data_i,
    output logic          slv0_rd_o,
    output logic          slv1_rd_o,
    output logic          slv2_rd_o,
    mcdf_arbiter_if.master fmt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_SEND     = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_winner;
    logic [2:0]    r_pkglen_sel;
    logic [5:0]    r_len;
    logic [4:0]    r_cnt;

    logic [2:0]    w_elig;
    logic [1:0]    w_prio [3];
    logic          w_found;
    logic [1:0]    w_best_id;
    logic [1:0]    w_best_prio;
    logic [2:0]    w_best_sel;
    logic [5:0]    w_len_m1;
    logic          w_end;
    logic [2:0]    w_rd;
    logic [DW-1:0] w_data;

    // Packet-length select to word count; unused codes fall back to 32.
    function automatic logic [5:0] f_decode_len(input logic [2:0] sel);
        logic [5:0] len;
        case (sel)
            3'b000:  len = 6'd4;
            3'b001:  len = 6'd8;
            3'b010:  len = 6'd16;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

    assign w_elig    = {slv2_req_i, slv1_req_i, slv0_req_i} & slv_en_i;
    assign w_prio[0] = slv0_prio_i;
    assign w_prio[1] = slv1_prio_i;
    assign w_prio[2] = slv2_prio_i;
    assign w_len_m1  = r_len - 6'd1;
    assign w_end     = (r_state == ST_SEND) && (r_cnt == w_len_m1[4:0]);

    // Winner search: strict less-than keeps ties on the lowest index.
    always_comb begin
        w_found     = 1'b0;
        w_best_id   = 2'b11;
        w_best_prio = 2'b11;
        for (int i = 0; i < 3; i++) begin
            if (w_elig[i] && (!w_found || (w_prio[i] < w_best_prio))) begin
                w_found     = 1'b1;
                w_best_id   = 2'(i);
                w_best_prio = w_prio[i];
            end else begin
                w_found     = w_found;
            end
        end
    end

    // Length select belonging to the current winner candidate.
    always_comb begin
        w_best_sel = 3'b000;
        case (w_best_id)
            2'd0:    w_best_sel = slv0_pkglen_i;
            2'd1:    w_best_sel = slv1_pkglen_i;
            2'd2:    w_best_sel = slv2_pkglen_i;
            default: w_best_sel = 3'b000;
        endcase
    end

    // Next-state logic; once committed the selection waits only for the ack.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (fmt.fmt_id_req_i && w_found) begin
                    w_state_nxt = ST_WAIT_ACK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (fmt.f2a_ack_i) begin
                    w_state_nxt = ST_SEND;
                end else begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_SEND: begin
                if (w_end) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Selection latch and in-packet word counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_winner     <= 2'b11;
            r_pkglen_sel <= 3'b000;
            r_len        <= 6'd0;
            r_cnt        <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt == ST_WAIT_ACK) begin
                        r_winner     <= w_best_id;
                        r_pkglen_sel <= w_best_sel;
                        r_len        <= f_decode_len(w_best_sel);
                    end
                    r_cnt <= 5'd0;
                end
                ST_WAIT_ACK: begin
                    if (fmt.f2a_ack_i) begin
                        r_cnt <= 5'd0;
                    end
                end
                ST_SEND: begin
                    r_cnt <= w_end ? 5'd0 : (r_cnt + 5'd1);
                end
                default: r_cnt <= 5'd0;
            endcase
        end
    end

    // Head-word mux and pop strobes for the winning channel during SEND.
    always_comb begin
        w_rd   = 3'b000;
        w_data = {DW{1'b0}};
        if (r_state == ST_SEND) begin
            case (r_winner)
                2'd0: begin w_rd = 3'b001; w_data = slv0_data_i; end
                2'd1: begin w_rd = 3'b010; w_data = slv1_data_i; end
                2'd2: begin w_rd = 3'b100; w_data = slv2_data_i; end
                default: begin w_rd = 3'b000; w_data = {DW{1'b0}}; end
            endcase
        end else begin
            w_rd   = 3'b000;
            w_data = {DW{1'b0}};
        end
    end

    assign slv0_rd_o            = w_rd[0];
    assign slv1_rd_o            = w_rd[1];
    assign slv2_rd_o            = w_rd[2];
    assign fmt.a2f_val_o        = (r_state == ST_SEND);
    assign fmt.a2f_end_o        = w_end;
    assign fmt.a2f_data_o       = w_data;
    assign fmt.a2f_id_o         = (r_state == ST_IDLE) ? 2'b11  : r_winner;
    assign fmt.a2f_pkglen_sel_o = (r_state == ST_IDLE) ? 3'b000 : r_pkglen_sel;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Scoreboard bench for mcdf_arbiter: directed packets push expected words,
// a negedge monitor pops and compares every presented word.
module tb_mcdf_arbiter;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]  id;
        logic [2:0]  sel;
        logic [31:0] data;
        logic        last;
        logic [2:0]  rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    en = 3'b111;
    logic [1:0]    prio [3];
    logic [2:0]    plen [3];
    logic [2:0]    req = 3'b000;
    logic [DW-1:0] data [3];
    logic [2:0]    rd;
    int            head [3];
    int            exp_cnt [3];
    exp_t          q [$];
    int            n_pass = 0;
    int            n_total = 0;
    bit            mon_en = 1'b0;

    mcdf_arbiter_if #(.DW(DW)) fmt_if ();

    mcdf_arbiter #(.DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .slv_en_i(en),
        .slv0_prio_i(prio[0]), .slv1_prio_i(prio[1]), .slv2_prio_i(prio[2]),
        .slv0_pkglen_i(plen[0]), .slv1_pkglen_i(plen[1]), .slv2_pkglen_i(plen[2]),
        .slv0_req_i(req[0]), .slv1_req_i(req[1]), .slv2_req_i(req[2]),
        .slv0_data_i(data[0]), .slv1_data_i(data[1]), .slv2_data_i(data[2]),
        .slv0_rd_o(rd[0]), .slv1_rd_o(rd[1]), .slv2_rd_o(rd[2]),
        .fmt(fmt_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_word(input int c, input int idx);
        return 32'hC000_0000 | (32'(c) << 24) | 32'(idx);
    endfunction

    // Show-ahead FIFO model: head advances on every sampled pop.
    always @(posedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (rd[c]) head[c] <= head[c] + 1;
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) data[c] = mk_word(c, head[c]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every valid word must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (mon_en) begin
            a = '{fmt_if.a2f_id_o, fmt_if.a2f_pkglen_sel_o, fmt_if.a2f_data_o,
                  fmt_if.a2f_end_o, rd};
            if (fmt_if.a2f_val_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 64'(a), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("word", 64'(a), 64'(e));
                end
            end else begin
                chk("idle_outputs", {fmt_if.a2f_end_o, rd, fmt_if.a2f_data_o},
                    {1'b0, 3'b000, 32'h0});
            end
        end
    end

    task automatic push_pkt(input int ch, input logic [2:0] sel, input int nwords, input int n);
        exp_t e;
        for (int k = 0; k < nwords; k++) begin
            e.id   = 2'(ch);
            e.sel  = sel;
            e.data = mk_word(ch, exp_cnt[ch] + k);
            e.last = (k == n - 1);
            e.rd   = 3'(1 << ch);
            q.push_back(e);
        end
        exp_cnt[ch] += nwords;
    endtask

    // Raise fmt_id_req for one edge and check the committed ID.
    task automatic select(input int ch, input logic [2:0] sel);
        fmt_if.fmt_id_req_i = 1'b1;
        @(posedge clk); #1;
        fmt_if.fmt_id_req_i = 1'b0;
        chk("sel_id", 64'(fmt_if.a2f_id_o), 64'(ch));
        chk("sel_pkglen", 64'(fmt_if.a2f_pkglen_sel_o), 64'(sel));
    endtask

    // Ack, let n words stream, then confirm the return to IDLE.
    task automatic ack_send(input int n, input bit stray);
        fmt_if.f2a_ack_i = 1'b1;
        @(posedge clk); #1;
        fmt_if.f2a_ack_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (stray && k == 1) fmt_if.f2a_ack_i = 1'b1;
            @(posedge clk); #1;
            fmt_if.f2a_ack_i = 1'b0;
        end
        chk("post_id", 64'(fmt_if.a2f_id_o), 64'(2'b11));
        chk("post_val", 64'(fmt_if.a2f_val_o), 64'(0));
    endtask

    task automatic pkt(input int ch, input logic [2:0] sel, input int n);
        select(ch, sel);
        push_pkt(ch, sel, n, n);
        ack_send(n, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int c = 0; c < 3; c++) begin
            prio[c] = 2'd0; plen[c] = 3'b000; head[c] = 0; exp_cnt[c] = 0;
        end
        fmt_if.fmt_id_req_i = 1'b0;
        fmt_if.f2a_ack_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs",
            {fmt_if.a2f_id_o, fmt_if.a2f_val_o, fmt_if.a2f_end_o, fmt_if.a2f_pkglen_sel_o, rd, fmt_if.a2f_data_o},
            {2'b11, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0});
        rst = 1'b0;
        mon_en = 1'b1;

        // Requests pending but formatter busy: no selection.
        req = 3'b010; prio[1] = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        chk("no_fmt_req_id", 64'(fmt_if.a2f_id_o), 64'(2'b11));

        // Single channel, ack two cycles after selection.
        select(1, 3'b000);
        push_pkt(1, 3'b000, 4, 4);
        @(posedge clk); #1;
        chk("wait_ack_id", 64'(fmt_if.a2f_id_o), 64'(1));
        ack_send(4, 1'b0);
        req = 3'b000;

        // Priority with tie on ch1/ch2.
        prio[0] = 2'd3; prio[1] = 2'd1; prio[2] = 2'd1; req = 3'b111;
        select(1, 3'b000); req[1] = 1'b0; push_pkt(1, 3'b000, 4, 4); ack_send(4, 1'b0);
        select(2, 3'b000); req[2] = 1'b0; push_pkt(2, 3'b000, 4, 4); ack_send(4, 1'b0);
        select(0, 3'b000); req[0] = 1'b0; push_pkt(0, 3'b000, 4, 4); ack_send(4, 1'b0);

        // Packet lengths.
        req = 3'b001;
        plen[0] = 3'b001; pkt(0, 3'b001, 8);
        plen[0] = 3'b010; pkt(0, 3'b010, 16);
        plen[0] = 3'b011; pkt(0, 3'b011, 32);
        plen[0] = 3'b111; pkt(0, 3'b111, 32);

        // Disabled channel never wins despite best priority.
        en = 3'b110; req = 3'b101; prio[0] = 2'd0; prio[2] = 2'd3; plen[2] = 3'b000;
        select(2, 3'b000); req = 3'b000; push_pkt(2, 3'b000, 4, 4); ack_send(4, 1'b0);
        en = 3'b111;

        // Commit: selection survives prio/req changes; stray ack in SEND ignored.
        req = 3'b100; prio[2] = 2'd3;
        select(2, 3'b000);
        push_pkt(2, 3'b000, 4, 4);
        prio[2] = 2'd0; req = 3'b001; prio[0] = 2'd0; plen[0] = 3'b001;
        fmt_if.fmt_id_req_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fmt_if.fmt_id_req_i = 1'b0;
        chk("commit_id", 64'(fmt_if.a2f_id_o), 64'(2));
        ack_send(4, 1'b1);
        select(0, 3'b001); req = 3'b000; push_pkt(0, 3'b001, 8, 8); ack_send(8, 1'b0);

        // Reset during word 5 of a 16-word packet.
        req = 3'b010; plen[1] = 3'b010;
        select(1, 3'b010);
        push_pkt(1, 3'b010, 6, 16);
        fmt_if.f2a_ack_i = 1'b1;
        @(posedge clk); #1;
        fmt_if.f2a_ack_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst", {fmt_if.a2f_val_o, fmt_if.a2f_id_o, rd}, {1'b0, 2'b11, 3'b000});
        plen[1] = 3'b000;
        pkt(1, 3'b000, 4);
        req = 3'b000;

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
